// File: rtl/usr_serial_rx.sv
// usr_serial_rx: deserializer for the USR serial output. Collects WIDTH
// strobed bits MSB-first or LSB-first and presents each finished word
// through a one-deep valid/ready holding register with a sticky overrun flag.
module usr_serial_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     bit_in,
    input  logic                     bit_en,
    input  logic                     dir,
    input  logic                     flush,
    input  logic                     ovr_clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             word_lsb;
    logic [WIDTH-1:0] shifted;
    logic             sample;
    logic             complete;
    logic             drain;

    // Next-state logic: shifting, counting, holding-register handoff, overrun.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        // The first bit of a word already uses the incoming order.
        word_lsb = (cnt_q == '0) ? dir : dir_q;
        shifted  = word_lsb ? {bit_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], bit_in};
        sample   = bit_en & ~flush;
        complete = sample & (cnt_q == LAST);
        drain    = valid_q & out_ready;

        if (flush) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (bit_en) begin
            sr_d = shifted;
            if (cnt_q == '0) begin
                dir_d = dir;
            end
            cnt_d = complete ? '0 : cnt_q + CW'(1);
        end

        if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        // A completing word either takes the (possibly draining) slot or is dropped;
        // a drop sets overrun after the clear so the set wins.
        if (complete) begin
            if (!valid_q || out_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Scoreboard bench for usr_serial_rx: directed scenarios followed by random
// traffic, checked against a bit-queue reference model of the receiver.
module tb_usr_serial_rx;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W);

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_en = 1'b0;
    logic          dir = 1'b0;
    logic          flush = 1'b0;
    logic          ovr_clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          overrun;
    logic [CW-1:0] bit_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit           bits[$];
    bit           m_dir = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    logic [W-1:0] exp_q[$];

    usr_serial_rx #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .bit_in   (bit_in),
        .bit_en   (bit_en),
        .dir      (dir),
        .flush    (flush),
        .ovr_clr  (ovr_clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        bits.delete();
        m_dir   = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        exp_q.delete();
    endfunction

    // One clock edge of the receiver, from the bit-order and handoff rules.
    function automatic void model_edge();
        bit           done = 1'b0;
        bit           drop = 1'b0;
        logic [W-1:0] word = '0;
        if (flush) begin
            bits.delete();
        end else if (bit_en) begin
            if (bits.size() == 0) m_dir = dir;
            bits.push_back(bit_in);
            if (bits.size() == W) begin
                // bit i of the arrival sequence lands at position i (LSB-first)
                // or W-1-i (MSB-first)
                for (int i = 0; i < W; i++)
                    if (bits[i]) word[m_dir ? i : W - 1 - i] = 1'b1;
                bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                exp_q.push_back(word);
                m_valid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (clr) model_reset();
        else model_edge();
        #2;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic d, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            bit_en = 1'b1;
            dir    = d;
            bit_in = d ? w[i] : w[W-1-i];
            if (i == W - 1) out_ready = rdy_last;
            tick();
        end
        bit_en = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Monitor: status against the model every cycle, data popped on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("bit_cnt", 32'(bit_cnt), 32'(bits.size()));
            if (out_valid && out_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept: unexpected word %0h, none expected at %0t", out_data, $time);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        model_reset();
        tick();
        tick();
        clr = 1'b0;
        tick();

        // Reset asserted between edges clears everything before the next edge.
        send_word(8'hA5, 1'b0, 1'b0);
        bit_en = 1'b1;
        bit_in = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        model_reset();
        #1;
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_cnt", 32'(bit_cnt), 32'h0);
        tick();
        clr = 1'b0;
        bit_en = 1'b0;
        tick();

        // MSB-first and LSB-first single-bit words
        send_word(8'h80, 1'b0, 1'b0);
        chk("msb_data", 32'(out_data), 32'h80);
        chk("msb_valid", 32'(out_valid), 32'h1);
        drain();
        send_word(8'h01, 1'b1, 1'b0);
        chk("lsb_data", 32'(out_data), 32'h01);
        drain();

        // dir change mid-word is ignored
        for (int i = 0; i < W; i++) begin
            bit_en = 1'b1;
            dir    = (i < 3) ? 1'b0 : 1'b1;
            bit_in = (i == 0);
            tick();
        end
        bit_en = 1'b0;
        chk("dir_hold_data", 32'(out_data), 32'h80);
        drain();

        // Overrun, its clear, then drain
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        chk("ovr_data", 32'(out_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);
        drain();
        chk("ovr_drain", 32'(out_valid), 32'h0);

        // Drain on the same edge as completion
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b1);
        out_ready = 1'b0;
        chk("sim_data", 32'(out_data), 32'h22);
        chk("sim_valid", 32'(out_valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);
        drain();

        // Flush together with a strobe discards the partial word and that bit
        for (int i = 0; i < 3; i++) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send_word(8'hC3, 1'b0, 1'b0);
        chk("flush_data", 32'(out_data), 32'hC3);
        chk("flush_cnt", 32'(bit_cnt), 32'h0);
        drain();

        // Reset mid-word
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1;
            bit_in = 1'(i & 1);
            tick();
        end
        bit_en = 1'b0;
        clr = 1'b1;
        model_reset();
        #2;
        clr = 1'b0;
        send_word(8'h5A, 1'b0, 1'b0);
        chk("rstmid_data", 32'(out_data), 32'h5A);
        chk("rstmid_ovr", 32'(overrun), 32'h0);
        drain();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit_en    = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
            dir       = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                clr = 1'b1;
                model_reset();
            end else begin
                clr = 1'b0;
            end
            tick();
        end

        // Drain whatever remains and confirm every expected word was delivered
        clr = 1'b0;
        bit_en = 1'b0;
        flush = 1'b0;
        ovr_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("all_delivered", 32'(exp_q.size()), 32'h0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
